l2tlb_xlat: RTL and testbench

Parametrised, caching successor to the pass-through L2 TLB. It holds ENTRIES fully-associative VPN→PPN translations, each tagged with one of SLOTS SPBTR checkpoint slots. It answers L1 TLB lookups directly on a hit, and issues one page-walk request per miss. A new SPBTR checkpoint on a slot invalidates every entry of that slot and sends a snoop to the L1 TLB. It sits inside the l2cache, between the L1 TLB request/ack channels and the directory-side walk path.

---
 rtl/l2tlb_xlat_if.sv | 74 +++++++
 rtl/l2tlb_xlat.sv | 198 +++++++++++++++++++
 tb/tb_l2tlb_xlat.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2tlb_xlat_if.sv
// l2tlb_xlat_if: lookup, response, walk, fill, checkpoint and snoop channels of the L2 TLB.
// Rev 1.0 - initial release.
`default_nettype none

interface l2tlb_xlat_if #(
    parameter int VPN_W = 27,
    parameter int PPN_W = 27,
    parameter int RID_W = 6,
    parameter int SLOTS = 4
);
    localparam int SLOT_W = $clog2(SLOTS);

    logic              req_valid;
    logic              req_retry;
    logic [RID_W-1:0]  req_rid;
    logic [VPN_W-1:0]  req_vpn;
    logic [SLOT_W-1:0] req_slot;

    logic              ack_valid;
    logic              ack_retry;
    logic [RID_W-1:0]  ack_rid;
    logic [PPN_W-1:0]  ack_ppn;
    logic              ack_fault;

    logic              walk_valid;
    logic              walk_retry;
    logic [VPN_W-1:0]  walk_vpn;
    logic [SLOT_W-1:0] walk_slot;

    logic              fill_valid;
    logic              fill_retry;
    logic [PPN_W-1:0]  fill_ppn;
    logic              fill_fault;

    logic              ckpt_valid;
    logic              ckpt_retry;
    logic [SLOT_W-1:0] ckpt_slot;

    logic              snoop_valid;
    logic              snoop_retry;
    logic [SLOT_W-1:0] snoop_slot;

    modport slave (
        input  req_valid, req_rid, req_vpn, req_slot,
        output req_retry,
        output ack_valid, ack_rid, ack_ppn, ack_fault,
        input  ack_retry,
        output walk_valid, walk_vpn, walk_slot,
        input  walk_retry,
        input  fill_valid, fill_ppn, fill_fault,
        output fill_retry,
        input  ckpt_valid, ckpt_slot,
        output ckpt_retry,
        output snoop_valid, snoop_slot,
        input  snoop_retry
    );

    modport master (
        output req_valid, req_rid, req_vpn, req_slot,
        input  req_retry,
        input  ack_valid, ack_rid, ack_ppn, ack_fault,
        output ack_retry,
        input  walk_valid, walk_vpn, walk_slot,
        output walk_retry,
        output fill_valid, fill_ppn, fill_fault,
        input  fill_retry,
        output ckpt_valid, ckpt_slot,
        input  ckpt_retry,
        input  snoop_valid, snoop_slot,
        output snoop_retry
    );
endinterface

`default_nettype wire

// File: rtl/l2tlb_xlat.sv
// l2tlb_xlat: fully-associative caching L2 TLB with per-slot SPBTR invalidation and L1 snoop.
// Rev 1.0 - initial release.
`default_nettype none

module l2tlb_xlat #(
    parameter int ENTRIES = 16,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 27,
    parameter int RID_W   = 6,
    parameter int SLOTS   = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    l2tlb_xlat_if.slave     bus
);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESP      = 3'd1,
        ST_WALK_REQ  = 3'd2,
        ST_WALK_WAIT = 3'd3,
        ST_SNOOP     = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ENTRIES-1:0] ent_valid;
    logic [VPN_W-1:0]   ent_vpn  [ENTRIES];
    logic [PPN_W-1:0]   ent_ppn  [ENTRIES];
    logic [SLOT_W-1:0]  ent_slot [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr;

    logic [RID_W-1:0]   lat_rid;
    logic [VPN_W-1:0]   lat_vpn;
    logic [SLOT_W-1:0]  lat_slot;
    logic [PPN_W-1:0]   resp_ppn;
    logic               resp_fault;
    logic [SLOT_W-1:0]  snp_slot;

    logic               hit;
    logic [PPN_W-1:0]   hit_ppn;
    logic [IDX_W-1:0]   victim;
    logic               all_valid;

    logic               req_fire;
    logic               ckpt_fire;
    logic               fill_fire;

    // Entries are unique per {vpn, slot}, so OR-folding the masked ppns yields the single hit.
    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_valid[i] && ent_vpn[i] == bus.req_vpn && ent_slot[i] == bus.req_slot) begin
                hit     = 1'b1;
                hit_ppn = hit_ppn | ent_ppn[i];
            end
        end
    end

    always_comb begin
        victim    = rr_ptr;
        all_valid = &ent_valid;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                victim = IDX_W'(i);
            end
        end
    end

    assign ckpt_fire = (state == ST_IDLE) && bus.ckpt_valid;
    assign req_fire  = (state == ST_IDLE) && !bus.ckpt_valid && bus.req_valid;
    assign fill_fire = (state == ST_WALK_WAIT) && bus.fill_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        bus.req_retry   = 1'b1;
        bus.ckpt_retry  = 1'b1;
        bus.fill_retry  = 1'b1;
        bus.ack_valid   = 1'b0;
        bus.walk_valid  = 1'b0;
        bus.snoop_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.ckpt_retry = 1'b0;
                // A simultaneous checkpoint wins; the lookup is pushed back for this cycle.
                bus.req_retry  = bus.ckpt_valid;
                if (bus.ckpt_valid) begin
                    state_nx = ST_SNOOP;
                end else if (bus.req_valid) begin
                    state_nx = hit ? ST_RESP : ST_WALK_REQ;
                end
            end
            ST_RESP: begin
                bus.ack_valid = 1'b1;
                if (!bus.ack_retry) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WALK_REQ: begin
                bus.walk_valid = 1'b1;
                if (!bus.walk_retry) begin
                    state_nx = ST_WALK_WAIT;
                end
            end
            ST_WALK_WAIT: begin
                bus.fill_retry = 1'b0;
                if (bus.fill_valid) begin
                    state_nx = ST_RESP;
                end
            end
            ST_SNOOP: begin
                bus.snoop_valid = 1'b1;
                if (!bus.snoop_retry) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid  <= '0;
            rr_ptr     <= '0;
            lat_rid    <= '0;
            lat_vpn    <= '0;
            lat_slot   <= '0;
            resp_ppn   <= '0;
            resp_fault <= 1'b0;
            snp_slot   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_vpn[i]  <= '0;
                ent_ppn[i]  <= '0;
                ent_slot[i] <= '0;
            end
        end else begin
            if (ckpt_fire) begin
                snp_slot <= bus.ckpt_slot;
                for (int i = 0; i < ENTRIES; i++) begin
                    if (ent_slot[i] == bus.ckpt_slot) begin
                        ent_valid[i] <= 1'b0;
                    end
                end
            end
            if (req_fire) begin
                lat_rid  <= bus.req_rid;
                lat_vpn  <= bus.req_vpn;
                lat_slot <= bus.req_slot;
                if (hit) begin
                    resp_ppn   <= hit_ppn;
                    resp_fault <= 1'b0;
                end
            end
            if (fill_fire) begin
                if (bus.fill_fault) begin
                    resp_ppn   <= '0;
                    resp_fault <= 1'b1;
                end else begin
                    ent_valid[victim] <= 1'b1;
                    ent_vpn[victim]   <= lat_vpn;
                    ent_ppn[victim]   <= bus.fill_ppn;
                    ent_slot[victim]  <= lat_slot;
                    resp_ppn          <= bus.fill_ppn;
                    resp_fault        <= 1'b0;
                    // Round-robin only advances when a live entry is evicted.
                    if (all_valid) begin
                        rr_ptr <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ack_rid    = lat_rid;
    assign bus.ack_ppn    = resp_ppn;
    assign bus.ack_fault  = resp_fault;
    assign bus.walk_vpn   = lat_vpn;
    assign bus.walk_slot  = lat_slot;
    assign bus.snoop_slot = snp_slot;

endmodule

`default_nettype wire

// File: tb/tb_l2tlb_xlat.sv
// tb_l2tlb_xlat: directed bench for l2tlb_xlat with a translation-table model and per-cycle output checker.
// Rev 1.0 - initial release.
`default_nettype none

module tb_l2tlb_xlat;
    localparam int ENTRIES = 16;
    localparam int VPN_W   = 27;
    localparam int PPN_W   = 27;
    localparam int RID_W   = 6;
    localparam int SLOTS   = 4;
    localparam int SLOT_W  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    l2tlb_xlat_if #(.VPN_W(VPN_W), .PPN_W(PPN_W), .RID_W(RID_W), .SLOTS(SLOTS)) bus ();

    l2tlb_xlat #(
        .ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W), .RID_W(RID_W), .SLOTS(SLOTS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [RID_W-1:0] rid;
        logic [PPN_W-1:0] ppn;
        logic             fault;
    } ack_t;

    typedef struct packed {
        logic [VPN_W-1:0]  vpn;
        logic [SLOT_W-1:0] slot;
    } walk_t;

    ack_t              exp_ack [$];
    walk_t             exp_walk [$];
    logic [SLOT_W-1:0] exp_snoop [$];

    ack_t  last_ack;
    walk_t last_walk;
    int    walk_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Translation-table model: a list of entries filled lowest-free-first, else round-robin.
    logic              m_valid [ENTRIES];
    logic [VPN_W-1:0]  m_vpn   [ENTRIES];
    logic [PPN_W-1:0]  m_ppn   [ENTRIES];
    logic [SLOT_W-1:0] m_slot  [ENTRIES];
    int                m_rr;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endfunction

    function automatic logic m_lookup(input logic [VPN_W-1:0] vpn, input logic [SLOT_W-1:0] slot,
                                      output logic [PPN_W-1:0] ppn);
        ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && m_vpn[i] == vpn && m_slot[i] == slot) begin
                ppn = m_ppn[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void m_install(input logic [VPN_W-1:0] vpn, input logic [SLOT_W-1:0] slot,
                                      input logic [PPN_W-1:0] ppn);
        int v = -1;
        for (int i = 0; i < ENTRIES; i++) if (v < 0 && !m_valid[i]) v = i;
        if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % ENTRIES;
        end
        m_valid[v] = 1'b1;
        m_vpn[v]   = vpn;
        m_ppn[v]   = ppn;
        m_slot[v]  = slot;
    endfunction

    function automatic void m_ckpt(input logic [SLOT_W-1:0] slot);
        for (int i = 0; i < ENTRIES; i++) if (m_slot[i] == slot) m_valid[i] = 1'b0;
    endfunction

    // Output checker: every transfer is matched against the expectation queues, held channels must stay stable.
    initial begin
        logic  hold_ack, hold_walk, hold_snp;
        ack_t  held_ack, cur_ack;
        walk_t held_walk, cur_walk;
        logic [SLOT_W-1:0] held_snp, e_snp;
        ack_t  e_ack;
        walk_t e_walk;
        hold_ack = 1'b0; hold_walk = 1'b0; hold_snp = 1'b0;
        held_ack = '0; held_walk = '0; held_snp = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_ack = 1'b0; hold_walk = 1'b0; hold_snp = 1'b0;
            end else begin
                cur_ack  = '{bus.ack_rid, bus.ack_ppn, bus.ack_fault};
                cur_walk = '{bus.walk_vpn, bus.walk_slot};
                if (hold_ack) begin
                    chk("ack_hold_valid", 64'(bus.ack_valid), 64'd1);
                    chk("ack_hold_payload", 64'(cur_ack), 64'(held_ack));
                end
                if (hold_walk) begin
                    chk("walk_hold_valid", 64'(bus.walk_valid), 64'd1);
                    chk("walk_hold_payload", 64'(cur_walk), 64'(held_walk));
                end
                if (hold_snp) begin
                    chk("snoop_hold_valid", 64'(bus.snoop_valid), 64'd1);
                    chk("snoop_hold_slot", 64'(bus.snoop_slot), 64'(held_snp));
                end
                if (bus.ack_valid || bus.walk_valid || bus.snoop_valid) begin
                    chk("busy_req_retry", 64'(bus.req_retry), 64'd1);
                    chk("busy_ckpt_retry", 64'(bus.ckpt_retry), 64'd1);
                    chk("busy_fill_retry", 64'(bus.fill_retry), 64'd1);
                end
                hold_ack  = bus.ack_valid && bus.ack_retry;   held_ack  = cur_ack;
                hold_walk = bus.walk_valid && bus.walk_retry; held_walk = cur_walk;
                hold_snp  = bus.snoop_valid && bus.snoop_retry; held_snp = bus.snoop_slot;
                if (bus.ack_valid && !bus.ack_retry) begin
                    last_ack = cur_ack;
                    if (exp_ack.size() == 0) chk("ack_unexpected", 64'(bus.ack_valid), 64'd0);
                    else begin
                        e_ack = exp_ack.pop_front();
                        chk("ack_payload", 64'(cur_ack), 64'(e_ack));
                    end
                end
                if (bus.walk_valid && !bus.walk_retry) begin
                    last_walk = cur_walk;
                    walk_count++;
                    if (exp_walk.size() == 0) chk("walk_unexpected", 64'(bus.walk_valid), 64'd0);
                    else begin
                        e_walk = exp_walk.pop_front();
                        chk("walk_payload", 64'(cur_walk), 64'(e_walk));
                    end
                end
                if (bus.snoop_valid && !bus.snoop_retry) begin
                    if (exp_snoop.size() == 0) chk("snoop_unexpected", 64'(bus.snoop_valid), 64'd0);
                    else begin
                        e_snp = exp_snoop.pop_front();
                        chk("snoop_slot", 64'(bus.snoop_slot), 64'(e_snp));
                    end
                end
            end
        end
    end

    // One lookup from IDLE to IDLE; hold>0 keeps ack_retry high for that many response cycles.
    task automatic do_lookup(input logic [RID_W-1:0] rid, input logic [VPN_W-1:0] vpn,
                             input logic [SLOT_W-1:0] slot, input logic [PPN_W-1:0] fppn,
                             input logic ffault, input int hold);
        logic             hit;
        logic [PPN_W-1:0] mppn;
        hit = m_lookup(vpn, slot, mppn);
        bus.req_valid = 1'b1;
        bus.req_rid   = rid;
        bus.req_vpn   = vpn;
        bus.req_slot  = slot;
        bus.ack_retry = (hold > 0);
        @(negedge clk);
        chk("req_accept", 64'(bus.req_retry), 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (hit) begin
            exp_ack.push_back('{rid, mppn, 1'b0});
        end else begin
            exp_walk.push_back('{vpn, slot});
            @(negedge clk);
            chk("walk_latency", 64'(bus.walk_valid), 64'd1);
            chk("no_ack_on_miss", 64'(bus.ack_valid), 64'd0);
            @(posedge clk); #1;
            bus.fill_valid = 1'b1;
            bus.fill_ppn   = fppn;
            bus.fill_fault = ffault;
            @(negedge clk);
            chk("fill_ready", 64'(bus.fill_retry), 64'd0);
            @(posedge clk); #1;
            bus.fill_valid = 1'b0;
            if (!ffault) m_install(vpn, slot, fppn);
            exp_ack.push_back('{rid, ffault ? {PPN_W{1'b0}} : fppn, ffault});
        end
        @(negedge clk);
        chk("ack_latency", 64'(bus.ack_valid), 64'd1);
        for (int n = 0; n < hold; n++) begin
            chk("req_retry_held", 64'(bus.req_retry), 64'd1);
            @(posedge clk); #1;
            if (n == hold - 1) bus.ack_retry = 1'b0;
            @(negedge clk);
            chk("ack_still_valid", 64'(bus.ack_valid), 64'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ack_valid"},  64'(bus.ack_valid), 64'd0);
        chk({tag, "_walk_valid"}, 64'(bus.walk_valid), 64'd0);
        chk({tag, "_snoop_valid"},64'(bus.snoop_valid), 64'd0);
        chk({tag, "_req_retry"},  64'(bus.req_retry), 64'd0);
        chk({tag, "_ckpt_retry"}, 64'(bus.ckpt_retry), 64'd0);
        chk({tag, "_fill_retry"}, 64'(bus.fill_retry), 64'd1);
        chk({tag, "_ent_valid"},  64'(dut.ent_valid), 64'd0);
        chk({tag, "_rr_ptr"},     64'(dut.rr_ptr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.req_valid = 1'b0; bus.req_rid = '0; bus.req_vpn = '0; bus.req_slot = '0;
        bus.ack_retry = 1'b0; bus.walk_retry = 1'b0;
        bus.fill_valid = 1'b0; bus.fill_ppn = '0; bus.fill_fault = 1'b0;
        bus.ckpt_valid = 1'b0; bus.ckpt_slot = '0; bus.snoop_retry = 1'b0;
        m_reset();

        @(negedge clk);
        check_reset_state("reset");
        chk("reset_ack_rid", 64'(bus.ack_rid), 64'd0);
        chk("reset_ack_ppn", 64'(bus.ack_ppn), 64'd0);
        chk("reset_walk_vpn", 64'(bus.walk_vpn), 64'd0);
        chk("reset_snoop_slot", 64'(bus.snoop_slot), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Cold miss, then hit with no walk.
        do_lookup(6'd5, 27'h123, 2'd1, 27'h4AB, 1'b0, 0);
        chk("cold_walk_vpn", 64'(last_walk.vpn), 64'h123);
        chk("cold_walk_slot", 64'(last_walk.slot), 64'd1);
        chk("cold_ack_rid", 64'(last_ack.rid), 64'd5);
        chk("cold_ack_ppn", 64'(last_ack.ppn), 64'h4AB);
        w = walk_count;
        do_lookup(6'd6, 27'h123, 2'd1, 27'h0, 1'b0, 0);
        chk("hit_no_walk", 64'(walk_count), 64'(w));
        chk("hit_ack_rid", 64'(last_ack.rid), 64'd6);
        chk("hit_ack_ppn", 64'(last_ack.ppn), 64'h4AB);

        // Faulting walk installs nothing.
        do_lookup(6'd7, 27'h200, 2'd1, 27'h777, 1'b1, 0);
        chk("fault_flag", 64'(last_ack.fault), 64'd1);
        chk("fault_ppn", 64'(last_ack.ppn), 64'd0);
        w = walk_count;
        do_lookup(6'd8, 27'h200, 2'd1, 27'h555, 1'b0, 0);
        chk("fault_remiss", 64'(walk_count), 64'(w + 1));

        // Slot isolation and checkpoint priority over a simultaneous lookup.
        do_lookup(6'd10, 27'h10, 2'd0, 27'h100, 1'b0, 0);
        do_lookup(6'd11, 27'h10, 2'd2, 27'h200, 1'b0, 0);
        bus.ckpt_valid = 1'b1; bus.ckpt_slot = 2'd2;
        bus.req_valid = 1'b1; bus.req_rid = 6'd12; bus.req_vpn = 27'h10; bus.req_slot = 2'd0;
        @(negedge clk);
        chk("ckpt_accept", 64'(bus.ckpt_retry), 64'd0);
        chk("ckpt_req_retry", 64'(bus.req_retry), 64'd1);
        @(posedge clk); #1;
        bus.ckpt_valid = 1'b0; bus.req_valid = 1'b0;
        m_ckpt(2'd2);
        exp_snoop.push_back(2'd2);
        @(negedge clk);
        chk("snoop_latency", 64'(bus.snoop_valid), 64'd1);
        chk("snoop_slot_lit", 64'(bus.snoop_slot), 64'd2);
        @(posedge clk); #1;
        w = walk_count;
        do_lookup(6'd13, 27'h10, 2'd0, 27'h0, 1'b0, 0);
        chk("slot0_hit", 64'(walk_count), 64'(w));
        chk("slot0_ppn", 64'(last_ack.ppn), 64'h100);
        do_lookup(6'd14, 27'h10, 2'd2, 27'h300, 1'b0, 0);
        chk("slot2_miss", 64'(walk_count), 64'(w + 1));

        // Response back-pressure for 3 cycles on a hit.
        do_lookup(6'd15, 27'h10, 2'd0, 27'h0, 1'b0, 3);
        chk("bp_ack_rid", 64'(last_ack.rid), 64'd15);

        // Replacement from a clean table.
        reset = 1'b0;
        m_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < ENTRIES; k++)
            do_lookup(RID_W'(k), VPN_W'(32'h1000 + k), 2'd3, PPN_W'(32'h2000 + k), 1'b0, 0);
        chk("full_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        do_lookup(6'd20, 27'h1010, 2'd3, 27'h2010, 1'b0, 0);
        chk("repl_rr_ptr", 64'(dut.rr_ptr), 64'd1);
        w = walk_count;
        for (int k = 1; k <= ENTRIES; k++)
            do_lookup(RID_W'(k), VPN_W'(32'h1000 + k), 2'd3, 27'h0, 1'b0, 0);
        chk("repl_others_hit", 64'(walk_count), 64'(w));
        do_lookup(6'd21, 27'h1000, 2'd3, 27'h2100, 1'b0, 0);
        chk("repl_oldest_miss", 64'(walk_count), 64'(w + 1));

        // Reset asserted while waiting for a fill.
        bus.req_valid = 1'b1; bus.req_rid = 6'd30; bus.req_vpn = 27'h555; bus.req_slot = 2'd1;
        exp_walk.push_back('{27'h555, 2'd1});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midmiss_walk", 64'(bus.walk_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midmiss_wait", 64'(bus.fill_retry), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        check_reset_state("midmiss");
        @(posedge clk); #1;
        reset = 1'b1;
        bus.fill_valid = 1'b1; bus.fill_ppn = 27'h999; bus.fill_fault = 1'b0;
        @(negedge clk);
        chk("late_fill_refused", 64'(bus.fill_retry), 64'd1);
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        @(negedge clk);
        chk("late_fill_no_ack", 64'(bus.ack_valid), 64'd0);
        chk("late_fill_no_install", 64'(dut.ent_valid), 64'd0);

        chk("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
        chk("walk_queue_drained", 64'(exp_walk.size()), 64'd0);
        chk("snoop_queue_drained", 64'(exp_snoop.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
